// File: rtl/bist_pkg.sv
// Definitions shared between the Bist controller and its result checker:
// the run FSM encoding and the width of the mismatch counter.
package bist_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } bist_state_t;

   // Two extra bits allow counting every word of the array with headroom
   function automatic int fail_cnt_width(input int adr_size);
      return adr_size + 2;
   endfunction

endpackage

// File: rtl/bist_log_fifo.sv
// First-word-fall-through storage for failing address/syndrome pairs.
// A pop on a full log frees the slot that a same-cycle push then uses.
module bist_log_fifo
   import bist_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

   logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
   logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
   logic [PW:0]      count_reg, count_next;
   logic [WIDTH-1:0] entry_data [DEPTH];
   logic             pop_ok;
   logic             push_ok;

   assign empty   = (count_reg == '0);
   assign full    = (count_reg == FULL_CNT);
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);
   assign dout    = empty ? '0 : entry_data[rd_ptr_reg];

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [WIDTH-1:0] data_reg;

      always_ff @(posedge clk) begin
         if (push_ok && !clr && (wr_ptr_reg == PW'(gi))) begin
            data_reg <= din;
         end
      end

      assign entry_data[gi] = data_reg;
   end

   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      count_next  = count_reg;
      if (clr) begin
         wr_ptr_next = '0;
         rd_ptr_next = '0;
         count_next  = '0;
      end else begin
         if (push_ok) begin
            wr_ptr_next = wr_ptr_reg + PW'(1);
         end
         if (pop_ok) begin
            rd_ptr_next = rd_ptr_reg + PW'(1);
         end
         case ({push_ok, pop_ok})
            2'b10:   count_next = count_reg + (PW + 1)'(1);
            2'b01:   count_next = count_reg - (PW + 1)'(1);
            default: count_next = count_reg;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
      end
   end

endmodule

// File: rtl/bist_fail_log.sv
// Compares Bist read-back words, counts mismatches, logs the first DEPTH
// failures and reports the final pass/fail status of a run.
module bist_fail_log
   import bist_pkg::*;
#(
   parameter int ADR_SIZE  = 4,
   parameter int DATA_SIZE = 8,
   parameter int DEPTH     = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start,
   input  logic                            cmp_valid,
   input  logic [ADR_SIZE-1:0]             cmp_addr,
   input  logic [DATA_SIZE-1:0]            cmp_exp,
   input  logic [DATA_SIZE-1:0]            cmp_act,
   input  logic                            test_done,
   input  logic                            log_rd,
   output logic [ADR_SIZE-1:0]             log_addr,
   output logic [DATA_SIZE-1:0]            log_syn,
   output logic                            log_empty,
   output logic                            overflow,
   output logic [fail_cnt_width(ADR_SIZE)-1:0] fail_cnt,
   output logic                            status,
   output logic                            done
);

   localparam int CW = fail_cnt_width(ADR_SIZE);
   localparam int LW = ADR_SIZE + DATA_SIZE;

   bist_state_t   state_reg, state_next;
   logic [CW-1:0] fail_cnt_reg, fail_cnt_next;
   logic          overflow_reg, overflow_next;
   logic          done_reg, done_next;
   logic          status_reg, status_next;
   logic          mismatch;
   logic          fifo_clr;
   logic          log_full;
   logic [LW-1:0] log_head;

   always_comb begin
      state_next    = state_reg;
      fail_cnt_next = fail_cnt_reg;
      overflow_next = overflow_reg;
      done_next     = done_reg;
      status_next   = status_reg;
      mismatch      = 1'b0;
      fifo_clr      = 1'b0;
      // start wins over any compare or test_done in the same cycle
      if (start) begin
         state_next    = RUN;
         fail_cnt_next = '0;
         overflow_next = 1'b0;
         done_next     = 1'b0;
         status_next   = 1'b0;
         fifo_clr      = 1'b1;
      end else begin
         case (state_reg)
            RUN: begin
               mismatch = cmp_valid && (cmp_exp != cmp_act);
               if (mismatch) begin
                  if (fail_cnt_reg != '1) begin
                     fail_cnt_next = fail_cnt_reg + CW'(1);
                  end
                  // a full log only drops the entry if no pop makes room
                  if (log_full && !log_rd) begin
                     overflow_next = 1'b1;
                  end
               end
               if (test_done) begin
                  state_next  = DONE;
                  done_next   = 1'b1;
                  status_next = (fail_cnt_reg == '0) && !mismatch;
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg    <= IDLE;
         fail_cnt_reg <= '0;
         overflow_reg <= 1'b0;
         done_reg     <= 1'b0;
         status_reg   <= 1'b0;
      end else begin
         state_reg    <= state_next;
         fail_cnt_reg <= fail_cnt_next;
         overflow_reg <= overflow_next;
         done_reg     <= done_next;
         status_reg   <= status_next;
      end
   end

   bist_log_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (LW)
   ) u_log (
      .clk   (clk),
      .rst   (rst),
      .clr   (fifo_clr),
      .push  (mismatch),
      .pop   (log_rd),
      .din   ({cmp_addr, cmp_exp ^ cmp_act}),
      .dout  (log_head),
      .empty (log_empty),
      .full  (log_full)
   );

   assign log_addr = log_head[LW-1:DATA_SIZE];
   assign log_syn  = log_head[DATA_SIZE-1:0];
   assign fail_cnt = fail_cnt_reg;
   assign overflow = overflow_reg;
   assign done     = done_reg;
   assign status   = status_reg;

endmodule
